// File: rtl/color_event_qualifier.sv
// Debounces a raw 2-bit color code into de-duplicated events, buffers them for a consumer and drives a held LED.
// Define COLOR_EVT_FIFO_EN for a 4-entry event FIFO; otherwise the buffer is a single register.
module color_event_qualifier #(
    parameter int STABLE_CYCLES = 1000,
    parameter int HOLD_CYCLES   = 50000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] c,
    input  logic       evt_ready,
    output logic       evt_valid,
    output logic [1:0] evt_color,
    output logic       led_r,
    output logic       led_g,
    output logic       led_b,
    output logic       evt_ovf,
    output logic [7:0] evt_count
);

    localparam logic [1:0] S_WAIT   = 2'd0;
    localparam logic [1:0] S_COUNT  = 2'd1;
    localparam logic [1:0] S_LOCKED = 2'd2;

    localparam logic L_OFF = 1'b0;
    localparam logic L_ON  = 1'b1;

    logic [1:0]  c_q;
    logic [1:0]  state;
    logic [1:0]  cand;
    logic [15:0] run_cnt;
    logic [1:0]  last_color;
    logic        accept;
    logic        new_evt;
    logic        pop;
    logic        full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) c_q <= 2'b00;
        else        c_q <= c;
    end

    // Accept fires in the cycle the run length reaches STABLE_CYCLES.
    assign accept  = (state == S_COUNT) && (c_q == cand) &&
                     (run_cnt == 16'(STABLE_CYCLES - 1));
    assign new_evt = accept && (c_q != 2'b00) && (c_q != last_color);
    assign pop     = evt_valid && evt_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_WAIT;
            cand    <= 2'b00;
            run_cnt <= 16'd0;
        end else if (c_q != cand) begin
            cand    <= c_q;
            run_cnt <= 16'd1;
            state   <= S_COUNT;
        end else if (state == S_COUNT) begin
            run_cnt <= run_cnt + 16'd1;
            if (accept) state <= S_LOCKED;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_color <= 2'b00;
            evt_count  <= 8'd0;
        end else if (accept) begin
            if (c_q == 2'b00) begin
                last_color <= 2'b00;
            end else if (new_evt) begin
                last_color <= c_q;
                evt_count  <= evt_count + 8'd1;
            end
        end
    end

`ifdef COLOR_EVT_FIFO_EN
    logic [1:0] mem [4];
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;
    logic [2:0] fill;
    logic       push_ok;

    assign full      = (fill == 3'd4);
    assign push_ok   = new_evt && (!full || pop);
    assign evt_valid = (fill != 3'd0);
    assign evt_color = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) mem[i] <= 2'b00;
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            fill   <= 3'd0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= c_q;
                wr_ptr      <= wr_ptr + 2'd1;
            end
            if (pop) rd_ptr <= rd_ptr + 2'd1;
            fill <= fill + {2'b00, push_ok} - {2'b00, pop};
        end
    end
`else
    logic       buf_vld;
    logic [1:0] buf_col;

    assign full      = buf_vld;
    assign evt_valid = buf_vld;
    assign evt_color = buf_col;

    // A push while the held event leaves this cycle replaces it in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_vld <= 1'b0;
            buf_col <= 2'b00;
        end else if (new_evt && (!buf_vld || pop)) begin
            buf_vld <= 1'b1;
            buf_col <= c_q;
        end else if (pop) begin
            buf_vld <= 1'b0;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                     evt_ovf <= 1'b0;
        else if (new_evt && full && !pop) evt_ovf <= 1'b1;
    end

    logic        led_state;
    logic [1:0]  led_color;
    logic [26:0] hold_cnt;

    // hold_cnt counts remaining on-cycles including the current one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_state <= L_OFF;
            led_color <= 2'b00;
            hold_cnt  <= 27'd0;
        end else if (new_evt) begin
            led_state <= L_ON;
            led_color <= c_q;
            hold_cnt  <= 27'(HOLD_CYCLES);
        end else if (led_state == L_ON) begin
            if (hold_cnt <= 27'd1) begin
                led_state <= L_OFF;
                led_color <= 2'b00;
                hold_cnt  <= 27'd0;
            end else begin
                hold_cnt <= hold_cnt - 27'd1;
            end
        end
    end

    assign led_r = (led_state == L_ON) && (led_color == 2'b11);
    assign led_g = (led_state == L_ON) && (led_color == 2'b10);
    assign led_b = (led_state == L_ON) && (led_color == 2'b01);

endmodule

// File: tb/tb_color_event_qualifier.sv
// Directed bench for color_event_qualifier (STABLE_CYCLES=4, HOLD_CYCLES=10) with a popping event scoreboard.
module tb_color_event_qualifier;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] c = 2'b00;
    logic       evt_ready = 1'b0;
    logic       evt_valid;
    logic [1:0] evt_color;
    logic       led_r, led_g, led_b;
    logic       evt_ovf;
    logic [7:0] evt_count;

    int checks = 0;
    int failures = 0;
    logic [1:0] exp_q [$];

    color_event_qualifier #(.STABLE_CYCLES(4), .HOLD_CYCLES(10)) dut (
        .clk(clk), .rst_n(rst_n), .c(c), .evt_ready(evt_ready),
        .evt_valid(evt_valid), .evt_color(evt_color),
        .led_r(led_r), .led_g(led_g), .led_b(led_b),
        .evt_ovf(evt_ovf), .evt_count(evt_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every transfer must match the oldest expected color.
    always @(negedge clk) begin
        logic [1:0] e;
        if (rst_n && evt_valid && evt_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected actual=%0d expected=none", evt_color);
            end else begin
                e = exp_q.pop_front();
                chk("sb_color", 32'(evt_color), 32'(e));
            end
        end
        if (rst_n) chk("led_onehot", 32'($countones({led_r, led_g, led_b}) <= 1), 32'd1);
    end

    task automatic cyc(input logic [1:0] code);
        @(posedge clk);
        #1;
        c = code;
    endtask

    task automatic hold(input logic [1:0] code, input int n);
        repeat (n) cyc(code);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        c = 2'b00;
        evt_ready = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_valid"}, 32'(evt_valid), 32'd0);
        chk({name, "_color"}, 32'(evt_color), 32'd0);
        chk({name, "_leds"},  32'({led_r, led_g, led_b}), 32'd0);
        chk({name, "_ovf"},   32'(evt_ovf), 32'd0);
        chk({name, "_count"}, 32'(evt_count), 32'd0);
    endtask

    initial begin
        logic [1:0] code;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Short red run is rejected, a full run is accepted.
        hold(2'b11, 3);
        hold(2'b00, 6);
        @(negedge clk);
        chk("short_count", 32'(evt_count), 32'd0);
        chk("short_valid", 32'(evt_valid), 32'd0);
        exp_q.push_back(2'b11);
        hold(2'b11, 4);
        cyc(2'b00);
        cyc(2'b00);
        @(negedge clk);
        chk("red_valid", 32'(evt_valid), 32'd1);
        chk("red_color", 32'(evt_color), 32'd3);
        chk("red_led", 32'(led_r), 32'd1);
        chk("red_count", 32'(evt_count), 32'd1);
        cyc(2'b00);
        evt_ready = 1'b1;
        hold(2'b00, 4);

        // Re-arm via 00, direct color changes, and a long hold.
        exp_q.push_back(2'b10);
        hold(2'b10, 6);
        hold(2'b00, 6);
        exp_q.push_back(2'b10);
        hold(2'b10, 6);
        hold(2'b00, 6);
        exp_q.push_back(2'b10);
        exp_q.push_back(2'b01);
        exp_q.push_back(2'b10);
        hold(2'b10, 6);
        hold(2'b01, 6);
        hold(2'b10, 6);
        hold(2'b00, 6);
        exp_q.push_back(2'b10);
        hold(2'b10, 100);
        hold(2'b00, 6);
        @(negedge clk);
        chk("dedup_count", 32'(evt_count), 32'd7);
        chk("dedup_drain", 32'(exp_q.size()), 32'd0);

        // LED hold timing and mid-hold color switch.
        do_reset();
        evt_ready = 1'b1;
        exp_q.push_back(2'b11);
        exp_q.push_back(2'b01);
        exp_q.push_back(2'b10);
        for (int j = 0; j <= 38; j++) begin
            code = (j < 4) ? 2'b11 : (j >= 17 && j <= 21) ? 2'b01 :
                   (j >= 22 && j <= 25) ? 2'b10 : 2'b00;
            cyc(code);
            @(negedge clk);
            chk("led_r", 32'(led_r), 32'(j >= 5 && j <= 14));
            chk("led_b", 32'(led_b), 32'(j >= 22 && j <= 26));
            chk("led_g", 32'(led_g), 32'(j >= 27 && j <= 36));
        end
        chk("led_count", 32'(evt_count), 32'd3);
        chk("led_drain", 32'(exp_q.size()), 32'd0);

        // Overflow with consumer stalled.
        do_reset();
        hold(2'b11, 5);
        hold(2'b10, 5);
        hold(2'b01, 5);
        hold(2'b11, 5);
        hold(2'b10, 5);
        hold(2'b01, 5);
        hold(2'b00, 4);
        @(negedge clk);
        chk("ovf_flag", 32'(evt_ovf), 32'd1);
        chk("ovf_count", 32'(evt_count), 32'd6);
        chk("ovf_valid", 32'(evt_valid), 32'd1);
        chk("ovf_head", 32'(evt_color), 32'd3);
`ifdef COLOR_EVT_FIFO_EN
        exp_q.push_back(2'b11);
        exp_q.push_back(2'b10);
        exp_q.push_back(2'b01);
        exp_q.push_back(2'b11);
`else
        exp_q.push_back(2'b11);
`endif
        cyc(2'b00);
        evt_ready = 1'b1;
        hold(2'b00, 8);
        @(negedge clk);
        chk("ovf_sticky", 32'(evt_ovf), 32'd1);
        chk("ovf_drain", 32'(exp_q.size()), 32'd0);
        chk("ovf_empty", 32'(evt_valid), 32'd0);

        // Push into a full buffer while the head is popped.
        do_reset();
        exp_q.push_back(2'b11);
        hold(2'b11, 5);
`ifdef COLOR_EVT_FIFO_EN
        exp_q.push_back(2'b10);
        exp_q.push_back(2'b01);
        exp_q.push_back(2'b11);
        hold(2'b10, 5);
        hold(2'b01, 5);
        hold(2'b11, 5);
`endif
        hold(2'b00, 2);
        exp_q.push_back(2'b10);
        hold(2'b10, 4);
        cyc(2'b00);
        evt_ready = 1'b1;
        cyc(2'b00);
        evt_ready = 1'b0;
        hold(2'b00, 2);
        @(negedge clk);
        chk("full_pop_ovf", 32'(evt_ovf), 32'd0);
`ifdef COLOR_EVT_FIFO_EN
        chk("full_pop_count", 32'(evt_count), 32'd5);
`else
        chk("full_pop_count", 32'(evt_count), 32'd2);
`endif
        chk("full_pop_head", 32'(evt_color), 32'd2);
        cyc(2'b00);
        evt_ready = 1'b1;
        hold(2'b00, 8);
        @(negedge clk);
        chk("full_pop_drain", 32'(exp_q.size()), 32'd0);
        chk("full_pop_ovf2", 32'(evt_ovf), 32'd0);

        // Asynchronous reset mid-hold and mid-count.
        do_reset();
        evt_ready = 1'b1;
        exp_q.push_back(2'b11);
        hold(2'b11, 4);
        hold(2'b00, 3);
        hold(2'b01, 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("async_rst");
        @(posedge clk);
        #1;
        evt_ready = 1'b0;
        exp_q.delete();
        rst_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            cyc(2'b01);
            @(negedge clk);
            chk("rst_requal_valid", 32'(evt_valid), 32'(k == 5));
        end
        chk("rst_requal_color", 32'(evt_color), 32'd1);
        exp_q.push_back(2'b01);
        cyc(2'b01);
        evt_ready = 1'b1;
        hold(2'b00, 3);
        @(negedge clk);
        chk("rst_requal_count", 32'(evt_count), 32'd1);
        chk("rst_requal_drain", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/color_event_qualifier.md
COLOR_EVENT_QUALIFIER -- requirements
Module: color_event_qualifier

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 1000: consecutive identical cycles of c required to accept a code (legal range 2..65535).
REQ-002 SHALL have parameter HOLD_CYCLES, default 50000000: LED on-time per event in clk cycles (legal range 1..2^26).
REQ-003 SHALL have port clk, input, 1: system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port c, input, 2: raw color code from the color stage; 00 none, 01 blue, 10 green, 11 red.
REQ-006 SHALL have port evt_ready, input, 1: consumer accepts the event head this cycle.
REQ-007 SHALL have port evt_valid, output, 1: event head available.
REQ-008 SHALL have port evt_color, output, 2: color of the event head.
REQ-009 SHALL have ports led_r, led_g, led_b, output, 1 each: one-hot color indicator.
REQ-010 SHALL have port evt_ovf, output, 1: sticky flag set on dropped event.
REQ-011 SHALL have port evt_count, output, 8: count of accepted events, wraps 255->0.

Function
REQ-012 SHALL register c once (c_q) before any use; all latencies below count from c_q.
REQ-013 Qualifier FSM SHALL have states WAIT, COUNT, LOCKED; c_q != candidate in any state -> candidate<=c_q, run counter<=1, state COUNT.
REQ-014 In COUNT with c_q == candidate, counter SHALL increment; on reaching STABLE_CYCLES SHALL issue a one-cycle accept and enter LOCKED.
REQ-015 LOCKED SHALL issue no further accepts until candidate changes; counter SHALL not wrap.
REQ-016 Accept of code 00 SHALL clear last_color to 00 (re-arm) and SHALL not create an event.
REQ-017 Accept of nonzero code equal to last_color SHALL be ignored; different code SHALL set last_color, create an event, increment evt_count in the same cycle.
REQ-018 Event SHALL be pushed the cycle after accept; evt_valid SHALL rise that cycle if buffer was empty (accept-to-valid latency 1).
REQ-019 Transfer SHALL occur when evt_valid and evt_ready both high; evt_color SHALL stay stable while evt_valid high and evt_ready low.
REQ-020 Push and pop in the same cycle SHALL both complete, including when full; no drop.
REQ-021 Push to full buffer without pop SHALL drop the new event and set evt_ovf; existing entries unchanged.
REQ-022 LED FSM states OFF, ON: an event SHALL load the LED for its color (11 r, 10 g, 01 b) and reload hold counter with HOLD_CYCLES, even if already ON.
REQ-023 ON SHALL return to OFF with all LEDs low after exactly HOLD_CYCLES cycles with no new event.
REQ-024 LED outputs SHALL be one-hot or all low, never more than one high.

Reset
REQ-025 rst_n low SHALL immediately force: qualifier WAIT, candidate 00, counter 0, last_color 00, buffer empty, evt_valid 0, evt_color 00, LEDs 0, evt_ovf 0, evt_count 0.
REQ-026 Reset mid-qualification or mid-hold SHALL discard all progress; after release, an already-present code SHALL need full STABLE_CYCLES again.
REQ-027 evt_ovf SHALL clear only by reset.

Configuration
REQ-028 Macro COLOR_EVT_FIFO_EN defined: event buffer SHALL be a 4-entry FIFO, in-order, full at 4 entries.
REQ-029 Macro undefined: buffer SHALL be a single register, full when evt_valid high; REQ-020/021 apply with depth 1.

Verification (bench uses STABLE_CYCLES=4, HOLD_CYCLES=10)
REQ-030 c=11 for 3 cycles then 00 -> no event, evt_count 0; c=11 held 4 cycles -> evt_valid, evt_color 11, led_r high, evt_count 1.
REQ-031 c=10 stable, 00 stable, 10 stable, evt_ready=1 -> two green events; c=10, 01, 10 without 00 gap -> three events; c=10 held 100 cycles -> one event.
REQ-032 Event at cycle t, no further events -> led high cycles t..t+9, low at t+10; second event at t+5 of other color -> switch LED, hold restarts.
REQ-033 evt_ready=0, six distinct events -> FIFO build: 4 retained in order, evt_ovf=1, evt_count 6; non-FIFO build: first retained, evt_ovf=1.
REQ-034 Full buffer, push with evt_ready=1 same cycle -> no drop, evt_ovf stays 0, ordering preserved.
REQ-035 rst_n low during LED hold and COUNT -> all outputs zero asynchronously; after release, c=01 needs 4 stable cycles before event.
